// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin CPU / external-host arbiter onto a single data-memory port,
// with store lane steering, load extension, misalignment faults and an access timeout.
module dmem_arbiter #(
  parameter int TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [2:0]  cpu_func3,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  output logic        cpu_stall,
  output logic        cpu_fault,
  input  logic        ext_req,
  input  logic        ext_we,
  input  logic [31:0] ext_addr,
  input  logic [31:0] ext_wdata,
  output logic        ext_done,
  output logic [31:0] ext_rdata,
  output logic        mem_en,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready
);
  localparam int CW = $clog2(TIMEOUT + 1);
  typedef enum logic [1:0] {IDLE, CPU_ACC, EXT_ACC} state_t;
  state_t state, next_state;
  logic last_ext, c_we, mis, grant_cpu, grant_ext, acc, tmo, acc_end;
  logic [2:0] c_f3;
  logic [31:0] c_addr, c_wdata, lane_data, shifted, load_val;
  logic [3:0] lane_strb;
  logic [CW-1:0] cnt;
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= next_state;
  // External accesses are captured as word ops (func3 = LW/SW) so one lane path serves both
  always_comb begin
    mis = (cpu_func3[1:0] == 2'd1 && cpu_addr[0]) || (cpu_func3[1] && cpu_addr[1:0] != 2'd0);
    grant_cpu = state == IDLE && !rst && cpu_req && (!ext_req || last_ext);
    grant_ext = state == IDLE && !rst && ext_req && !grant_cpu;
    acc = state != IDLE;
    tmo = acc && cnt == CW'(TIMEOUT) && !mem_ready;
    acc_end = acc && (mem_ready || tmo);
    next_state = acc_end ? IDLE : (grant_cpu && !mis) ? CPU_ACC : grant_ext ? EXT_ACC : state;
    lane_strb = c_f3[1] ? 4'b1111 : c_f3[0] ? (4'b0011 << {c_addr[1], 1'b0}) : (4'b0001 << c_addr[1:0]);
    lane_data = c_f3[1] ? c_wdata : c_f3[0] ? {2{c_wdata[15:0]}} : {4{c_wdata[7:0]}};
    shifted = mem_rdata >> {c_addr[1:0], 3'b000};
    load_val = c_f3[1] ? shifted
             : c_f3[0] ? {{16{~c_f3[2] & shifted[15]}}, shifted[15:0]}
             : {{24{~c_f3[2] & shifted[7]}}, shifted[7:0]};
    mem_en = acc;
    mem_we = acc && c_we;
    mem_addr = acc ? {c_addr[31:2], 2'b00} : '0;
    mem_wdata = (acc && c_we) ? lane_data : '0;
    mem_wstrb = (acc && c_we) ? lane_strb : '0;
    cpu_rdata = (state == CPU_ACC && mem_ready && !c_we) ? load_val : '0;
    cpu_fault = (grant_cpu && mis) || (state == CPU_ACC && tmo);
    cpu_stall = cpu_req && !(cpu_fault || (state == CPU_ACC && mem_ready));
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      last_ext <= 1'b1;
      cnt <= '0;
      ext_done <= 1'b0;
      ext_rdata <= '0;
      c_we <= 1'b0;
      c_f3 <= '0;
      c_addr <= '0;
      c_wdata <= '0;
    end else begin
      cnt <= (acc && !acc_end) ? cnt + 1'b1 : '0;
      ext_done <= state == EXT_ACC && acc_end;
      if (state == EXT_ACC && acc_end) ext_rdata <= mem_ready ? mem_rdata : '0;
      if (grant_cpu || grant_ext) begin
        last_ext <= grant_ext;
        c_we <= grant_ext ? ext_we : cpu_we;
        c_f3 <= grant_ext ? 3'b010 : cpu_func3;
        c_addr <= grant_ext ? ext_addr : cpu_addr;
        c_wdata <= grant_ext ? ext_wdata : cpu_wdata;
      end
    end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: randomized and directed checks of dmem_arbiter against a byte-level reference model.
module tb_dmem_arbiter;
  localparam int TO = 15;
  logic clk = 1'b0, rst = 1'b1;
  logic cpu_req = 1'b0, cpu_we = 1'b0;
  logic [2:0] cpu_func3 = '0;
  logic [31:0] cpu_addr = '0, cpu_wdata = '0;
  logic [31:0] cpu_rdata;
  logic cpu_stall, cpu_fault;
  logic ext_req = 1'b0, ext_we = 1'b0;
  logic [31:0] ext_addr = '0, ext_wdata = '0;
  logic ext_done;
  logic [31:0] ext_rdata;
  logic mem_en, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0] mem_wstrb;
  logic [31:0] mem_rdata = '0;
  logic mem_ready = 1'b0;
  int total = 0, passed = 0;

  dmem_arbiter #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_func3(cpu_func3), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall), .cpu_fault(cpu_fault),
    .ext_req(ext_req), .ext_we(ext_we), .ext_addr(ext_addr), .ext_wdata(ext_wdata),
    .ext_done(ext_done), .ext_rdata(ext_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  always #5 clk = ~clk;

  function automatic int m_size(input logic [2:0] f3);
    return (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
  endfunction

  function automatic logic [3:0] m_strb(input logic [2:0] f3, input logic [31:0] a);
    int n, off;
    n = m_size(f3);
    off = int'(a % 32'd4);
    return 4'(((1 << n) - 1) << off);
  endfunction

  function automatic logic [31:0] m_mask(input logic [3:0] s);
    logic [31:0] m;
    m = '0;
    for (int i = 0; i < 4; i++) if (s[i]) m = m | (32'hFF << (8 * i));
    return m;
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
    logic [31:0] res;
    int off;
    res = '0;
    off = int'(a % 32'd4);
    for (int i = 0; i < m_size(f3); i++) res = res | (((wd >> (8 * i)) & 32'hFF) << (8 * (i + off)));
    return res;
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] rd);
    int n;
    logic [31:0] m, v;
    n = m_size(f3);
    m = (n == 4) ? 32'hFFFF_FFFF : (32'h1 << (8 * n)) - 32'h1;
    v = (rd >> (8 * int'(a % 32'd4))) & m;
    if (!f3[2] && n < 4 && v[8 * n - 1]) v = v | ~m;
    return v;
  endfunction

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    cpu_req = 1'b0;
    #1;
    total++; if (cpu_stall !== 1'b0) $display("FAIL rst_stall_idle got %b exp 0", cpu_stall); else passed++;
    total++; if ({mem_en, mem_we, mem_wstrb} !== 6'b0 || mem_addr !== 32'h0 || mem_wdata !== 32'h0)
      $display("FAIL rst_mem got en=%b we=%b strb=%h addr=%h wdata=%h exp all 0", mem_en, mem_we, mem_wstrb, mem_addr, mem_wdata);
    else passed++;
    total++; if (ext_done !== 1'b0 || ext_rdata !== 32'h0 || cpu_fault !== 1'b0)
      $display("FAIL rst_outs got done=%b rdata=%h fault=%b exp 0", ext_done, ext_rdata, cpu_fault);
    else passed++;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_func3 = 3'b010; cpu_addr = 32'h6;
    #1;
    total++; if (cpu_stall !== 1'b1 || cpu_fault !== 1'b0 || mem_en !== 1'b0)
      $display("FAIL rst_req got stall=%b fault=%b en=%b exp 1 0 0", cpu_stall, cpu_fault, mem_en);
    else passed++;
    cpu_req = 1'b0;
    step;
    rst = 1'b0;
  endtask

  task automatic test_cpu_access(input logic [2:0] f3, input logic we, input logic [31:0] addr,
                                 input logic [31:0] wd, input logic [31:0] rd, input int delay);
    logic [3:0] es;
    logic [31:0] er;
    es = we ? m_strb(f3, addr) : 4'h0;
    er = we ? 32'h0 : m_load(f3, addr, rd);
    step;
    cpu_req = 1'b1; cpu_we = we; cpu_func3 = f3; cpu_addr = addr; cpu_wdata = wd;
    #1;
    total++; if (cpu_stall !== 1'b1 || cpu_fault !== 1'b0 || mem_en !== 1'b0)
      $display("FAIL cpu_grant f3=%0d addr=%h got stall=%b fault=%b en=%b exp 1 0 0", f3, addr, cpu_stall, cpu_fault, mem_en);
    else passed++;
    for (int i = 0; i <= delay; i++) begin
      step;
      if (i == delay) begin mem_ready = 1'b1; mem_rdata = rd; end
      #1;
      total++; if (mem_en !== 1'b1 || mem_addr !== addr - (addr % 32'd4) || mem_we !== we || mem_wstrb !== es ||
                   (mem_wdata & m_mask(es)) !== (m_wdata(f3, addr, wd) & m_mask(es)))
        $display("FAIL cpu_mem f3=%0d we=%b addr=%h got en=%b a=%h we=%b strb=%h wd=%h exp a=%h strb=%h wd=%h",
                 f3, we, addr, mem_en, mem_addr, mem_we, mem_wstrb, mem_wdata, addr - (addr % 32'd4), es, m_wdata(f3, addr, wd));
      else passed++;
      total++; if (cpu_stall !== (i != delay) || cpu_fault !== 1'b0 || cpu_rdata !== ((i == delay) ? er : 32'h0))
        $display("FAIL cpu_resp f3=%0d addr=%h cyc=%0d got stall=%b fault=%b rdata=%h exp stall=%b rdata=%h",
                 f3, addr, i, cpu_stall, cpu_fault, cpu_rdata, i != delay, (i == delay) ? er : 32'h0);
      else passed++;
    end
    step;
    cpu_req = 1'b0; mem_ready = 1'b0;
    #1;
    total++; if (mem_en !== 1'b0 || cpu_stall !== 1'b0)
      $display("FAIL cpu_after got en=%b stall=%b exp 0 0", mem_en, cpu_stall);
    else passed++;
  endtask

  task automatic test_cpu_directed;
    test_cpu_access(3'b000, 1'b0, 32'h103, 32'h0, 32'h80FF_1234, 0);
    test_cpu_access(3'b001, 1'b1, 32'h202, 32'h0000_ABCD, 32'h0, 1);
  endtask

  task automatic test_cpu_random;
    logic [2:0] f3;
    logic we;
    logic [31:0] addr;
    for (int k = 0; k < 24; k++) begin
      we = 1'($urandom_range(0, 1));
      f3 = 3'($urandom_range(0, 2));
      if (!we && f3 != 3'd2 && $urandom_range(0, 1) == 1) f3[2] = 1'b1;
      addr = $urandom;
      addr = addr - (addr % 32'(m_size(f3)));
      test_cpu_access(f3, we, addr, $urandom, $urandom, int'($urandom_range(0, 3)));
    end
  endtask

  task automatic test_misaligned;
    logic [2:0] mf[5] = '{3'b010, 3'b001, 3'b010, 3'b101, 3'b001};
    logic [31:0] ma[5] = '{32'h6, 32'h101, 32'h3, 32'h7, 32'h3};
    logic mw[5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    for (int k = 0; k < 5; k++) begin
      step;
      cpu_req = 1'b1; cpu_we = mw[k]; cpu_func3 = mf[k]; cpu_addr = ma[k];
      #1;
      total++; if (cpu_fault !== 1'b1 || cpu_stall !== 1'b0 || mem_en !== 1'b0)
        $display("FAIL misalign f3=%0d addr=%h got fault=%b stall=%b en=%b exp 1 0 0", mf[k], ma[k], cpu_fault, cpu_stall, mem_en);
      else passed++;
      step;
      cpu_req = 1'b0;
      #1;
      total++; if (mem_en !== 1'b0 || cpu_fault !== 1'b0)
        $display("FAIL misalign_after addr=%h got en=%b fault=%b exp 0 0", ma[k], mem_en, cpu_fault);
      else passed++;
    end
  endtask

  task automatic test_ext;
    logic we;
    logic [31:0] addr, wd, rd;
    int delay;
    for (int k = 0; k < 8; k++) begin
      we = 1'($urandom_range(0, 1));
      addr = $urandom; wd = $urandom; rd = $urandom;
      delay = int'($urandom_range(0, 3));
      step;
      ext_req = 1'b1; ext_we = we; ext_addr = addr; ext_wdata = wd;
      #1;
      total++; if (mem_en !== 1'b0 || ext_done !== 1'b0)
        $display("FAIL ext_grant got en=%b done=%b exp 0 0", mem_en, ext_done);
      else passed++;
      for (int i = 0; i <= delay; i++) begin
        step;
        ext_req = 1'b0;
        if (i == delay) begin mem_ready = 1'b1; mem_rdata = rd; end
        #1;
        total++; if (mem_en !== 1'b1 || mem_addr !== addr - (addr % 32'd4) || mem_we !== we ||
                     mem_wstrb !== (we ? 4'hF : 4'h0) || (we && mem_wdata !== wd) || ext_done !== 1'b0)
          $display("FAIL ext_mem we=%b addr=%h got en=%b a=%h we=%b strb=%h wd=%h done=%b exp wd=%h",
                   we, addr, mem_en, mem_addr, mem_we, mem_wstrb, mem_wdata, ext_done, wd);
        else passed++;
      end
      step;
      mem_ready = 1'b0;
      #1;
      total++; if (ext_done !== 1'b1 || mem_en !== 1'b0 || (!we && ext_rdata !== rd))
        $display("FAIL ext_done we=%b got done=%b en=%b rdata=%h exp 1 0 %h", we, ext_done, mem_en, ext_rdata, rd);
      else passed++;
    end
  endtask

  task automatic test_contention;
    logic [31:0] r;
    r = $urandom;
    step;
    ext_req = 1'b1; ext_we = 1'b0; ext_addr = 32'h600; mem_ready = 1'b0;
    step;
    ext_req = 1'b0;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_func3 = 3'b010; cpu_addr = 32'h700;
    #1;
    for (int i = 0; i < 2; i++) begin
      total++; if (cpu_stall !== 1'b1 || mem_addr !== 32'h600)
        $display("FAIL wait_stall got stall=%b addr=%h exp 1 00000600", cpu_stall, mem_addr);
      else passed++;
      step;
      #1;
    end
    cpu_req = 1'b0; mem_ready = 1'b1; mem_rdata = r;
    #1;
    total++; if (cpu_stall !== 1'b0 || mem_en !== 1'b1)
      $display("FAIL drop_req got stall=%b en=%b exp 0 1", cpu_stall, mem_en);
    else passed++;
    step;
    #1;
    total++; if (mem_en !== 1'b0 || ext_done !== 1'b1 || ext_rdata !== r)
      $display("FAIL contention_done got en=%b done=%b rdata=%h exp 0 1 %h", mem_en, ext_done, ext_rdata, r);
    else passed++;
    step;
    #1;
    total++; if (mem_en !== 1'b0 || ext_done !== 1'b0 || cpu_fault !== 1'b0)
      $display("FAIL idle_ready got en=%b done=%b fault=%b exp 0 0 0", mem_en, ext_done, cpu_fault);
    else passed++;
    mem_ready = 1'b0;
  endtask

  task automatic test_timeout;
    int n;
    step;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_func3 = 3'b010; cpu_addr = 32'h40;
    mem_ready = 1'b0; mem_rdata = 32'hDEAD_BEEF;
    step;
    #1;
    n = 0;
    while (cpu_fault !== 1'b1 && n < 100) begin
      total++; if (mem_en !== 1'b1 || cpu_stall !== 1'b1)
        $display("FAIL tmo_wait cyc=%0d got en=%b stall=%b exp 1 1", n, mem_en, cpu_stall);
      else passed++;
      step;
      #1;
      n++;
    end
    total++; if (n !== TO) $display("FAIL tmo_cpu_cycles got %0d exp %0d", n, TO); else passed++;
    total++; if (cpu_stall !== 1'b0 || cpu_rdata !== 32'h0)
      $display("FAIL tmo_cpu_resp got stall=%b rdata=%h exp 0 0", cpu_stall, cpu_rdata);
    else passed++;
    step;
    cpu_req = 1'b0;
    #1;
    total++; if (mem_en !== 1'b0 || cpu_fault !== 1'b0)
      $display("FAIL tmo_cpu_idle got en=%b fault=%b exp 0 0", mem_en, cpu_fault);
    else passed++;
    step;
    ext_req = 1'b1; ext_we = 1'b0; ext_addr = 32'h500;
    step;
    ext_req = 1'b0;
    #1;
    n = 0;
    while (mem_en === 1'b1 && n < 100) begin
      step;
      #1;
      n++;
    end
    total++; if (n !== TO + 1) $display("FAIL tmo_ext_cycles got %0d exp %0d", n, TO + 1); else passed++;
    total++; if (ext_done !== 1'b1 || ext_rdata !== 32'h0)
      $display("FAIL tmo_ext_done got done=%b rdata=%h exp 1 0", ext_done, ext_rdata);
    else passed++;
    step;
    #1;
    total++; if (ext_done !== 1'b0) $display("FAIL tmo_ext_pulse got %b exp 0", ext_done); else passed++;
  endtask

  task automatic test_round_robin;
    int src;
    step;
    rst = 1'b1;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_func3 = 3'b010; cpu_addr = 32'h100;
    ext_req = 1'b1; ext_we = 1'b0; ext_addr = 32'h200;
    mem_ready = 1'b1; mem_rdata = $urandom;
    step;
    rst = 1'b0;
    // each grant takes a grant cycle plus one access cycle; grants alternate starting with the CPU
    for (int c = 0; c < 8; c++) begin
      #1;
      src = (c / 2) % 2;
      total++; if (mem_en !== 1'(c % 2) || ((c % 2) == 1 && mem_addr !== (src == 1 ? 32'h200 : 32'h100)))
        $display("FAIL rr cyc=%0d got en=%b addr=%h exp en=%0d src=%0d", c, mem_en, mem_addr, c % 2, src);
      else passed++;
      total++; if (cpu_stall !== !((c % 2) == 1 && src == 0))
        $display("FAIL rr_stall cyc=%0d got %b exp %b", c, cpu_stall, !((c % 2) == 1 && src == 0));
      else passed++;
      step;
    end
    cpu_req = 1'b0; ext_req = 1'b0; mem_ready = 1'b0;
  endtask

  task automatic test_reset_mid_ext;
    logic [31:0] r;
    r = $urandom;
    step;
    ext_req = 1'b1; ext_we = 1'b1; ext_addr = 32'h300; ext_wdata = $urandom;
    step;
    ext_req = 1'b0;
    #1;
    total++; if (mem_en !== 1'b1 || mem_wstrb !== 4'hF)
      $display("FAIL mid_acc got en=%b strb=%h exp 1 f", mem_en, mem_wstrb);
    else passed++;
    rst = 1'b1; mem_ready = 1'b1;
    #1;
    total++; if (mem_en !== 1'b0 || mem_wstrb !== 4'h0 || mem_addr !== 32'h0)
      $display("FAIL mid_rst got en=%b strb=%h addr=%h exp 0", mem_en, mem_wstrb, mem_addr);
    else passed++;
    step;
    #1;
    total++; if (ext_done !== 1'b0) $display("FAIL mid_rst_done got %b exp 0", ext_done); else passed++;
    rst = 1'b0; mem_ready = 1'b0;
    step;
    #1;
    total++; if (ext_done !== 1'b0 || mem_en !== 1'b0)
      $display("FAIL post_rst got done=%b en=%b exp 0 0", ext_done, mem_en);
    else passed++;
    step;
    ext_req = 1'b1; ext_we = 1'b0; ext_addr = 32'h304;
    step;
    ext_req = 1'b0;
    #1;
    total++; if (mem_en !== 1'b1 || mem_addr !== 32'h304 || mem_we !== 1'b0)
      $display("FAIL post_rst_grant got en=%b addr=%h we=%b exp 1 00000304 0", mem_en, mem_addr, mem_we);
    else passed++;
    mem_ready = 1'b1; mem_rdata = r;
    step;
    mem_ready = 1'b0;
    #1;
    total++; if (ext_done !== 1'b1 || ext_rdata !== r)
      $display("FAIL post_rst_done got done=%b rdata=%h exp 1 %h", ext_done, ext_rdata, r);
    else passed++;
  endtask

  initial begin
    test_reset;
    test_cpu_directed;
    test_cpu_random;
    test_misaligned;
    test_ext;
    test_contention;
    test_timeout;
    test_round_robin;
    test_reset_mid_ext;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired after %0d checks", total);
    $fatal(1, "watchdog");
  end
endmodule
